// File: rtl/pipe_addsub_pkg.sv
// Shared sizing constants for the pipelined adder/subtractor.
// chunk_w derives the per-stage slice width and never divides by zero.
package pipe_addsub_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_w(input int width, input int stages);
        return (stages < 1) ? width : width / stages;
    endfunction

    localparam int DEF_CHUNK = chunk_w(DEF_WIDTH, DEF_STAGES);

endpackage

// File: rtl/pipe_addsub_rca_chunk.sv
// Combinational N-bit ripple-carry slice built from full-adder cells.
// Besides the carry-out it exposes the carry into the MSB, which the top slice uses for overflow.
module rca_chunk
    import pipe_addsub_pkg::*;
#(
    parameter int N = DEF_CHUNK
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] s_o,
    output logic         c_o,
    output logic         c_msb_o
);

    logic [N:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o     = c[N];
    assign c_msb_o = c[N - 1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement add/sub: one CHUNK-bit slice per stage, carry registered between stages.
// Upper operand slices ride along in skew registers; resolved lower slices grow stage by stage.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_chk
        $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES must be >= 1");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0_eff;

    // Single global enable: the whole pipe freezes while the output is held.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;
    assign c0_eff   = cin ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int RW = (k + 1) * CHUNK;
        localparam int SW = WIDTH - RW;

        logic [CHUNK-1:0] op_a, op_b, s_chunk;
        logic             c_in, c_out, c_msb, vld_in, load;
        logic             vld_q, vld_d, cy_q, cy_d;
        logic [RW-1:0]    res_q, res_d, res_new;

        if (k == 0) begin : g_src
            assign op_a    = a[CHUNK-1:0];
            assign op_b    = b_eff[CHUNK-1:0];
            assign c_in    = c0_eff;
            assign vld_in  = in_valid;
            assign res_new = s_chunk;
        end else begin : g_src
            assign op_a    = g_stg[k-1].g_skew.a_q[CHUNK-1:0];
            assign op_b    = g_stg[k-1].g_skew.b_q[CHUNK-1:0];
            assign c_in    = g_stg[k-1].cy_q;
            assign vld_in  = g_stg[k-1].vld_q;
            assign res_new = {s_chunk, g_stg[k-1].res_q};
        end

        rca_chunk #(.N(CHUNK)) u_rca (
            .a_i     (op_a),
            .b_i     (op_b),
            .c_i     (c_in),
            .s_o     (s_chunk),
            .c_o     (c_out),
            .c_msb_o (c_msb)
        );

        // Data registers only load on a real beat, so bubbles leave them untouched.
        assign load = advance && vld_in;

        always_comb begin
            vld_d = vld_q;
            cy_d  = cy_q;
            res_d = res_q;
            if (advance) begin
                vld_d = vld_in;
            end
            if (load) begin
                cy_d  = c_out;
                res_d = res_new;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                res_q <= '0;
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                res_q <= res_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [SW-1:0] a_q, a_d, a_new;
            logic [SW-1:0] b_q, b_d, b_new;

            if (k == 0) begin : g_feed
                assign a_new = a[WIDTH-1:CHUNK];
                assign b_new = b_eff[WIDTH-1:CHUNK];
            end else begin : g_feed
                assign a_new = g_stg[k-1].g_skew.a_q[WIDTH-k*CHUNK-1:CHUNK];
                assign b_new = g_stg[k-1].g_skew.b_q[WIDTH-k*CHUNK-1:CHUNK];
            end

            assign a_d = load ? a_new : a_q;
            assign b_d = load ? b_new : b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_top
            logic ov_q, ov_d;

            assign ov_d = load ? (c_msb ^ c_out) : ov_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ov_q <= 1'b0;
                end else begin
                    ov_q <= ov_d;
                end
            end
        end else begin : g_low
            logic c_msb_unused;
            assign c_msb_unused = c_msb;
        end
    end

    assign out_valid = g_stg[STAGES-1].vld_q;
    assign sum       = g_stg[STAGES-1].res_q;
    assign cout      = g_stg[STAGES-1].cy_q;
    assign ovf       = g_stg[STAGES-1].g_top.ov_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub at WIDTH=16, STAGES=4.
module tb_pipe_addsub;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, cin, sub;
    logic         out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, sum}; overflow from operand/result signs.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        logic [15:0] be;
        logic        ce;
        logic [16:0] r;
        logic        o;
        be = s ? ~y : y;
        ce = s ? ~c : c;
        r  = {1'b0, x} + {1'b0, be} + {16'b0, ce};
        o  = (x[15] == be[15]) && (r[15] != x[15]);
        return {o, r[16], r[15:0]};
    endfunction

    task automatic one_beat(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, input logic xs,
                            input logic [15:0] esum, input logic ecout, input logic eovf);
        a = xa; b = xb; cin = xc; sub = xs;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < S - 1; i++) begin
            check({tag, "_early_valid"}, out_valid, 0);
            tick();
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"},   sum,       esum);
        check({tag, "_cout"},  cout,      ecout);
        check({tag, "_ovf"},   ovf,       eovf);
        tick();
        check({tag, "_drained"}, out_valid, 0);
    endtask

    task automatic run_stream(input string tag, input int nbeats, input int st_start,
                              input int st_len, input int ncyc,
                              output int first, output int last);
        logic [17:0] q[$];
        logic [17:0] cur;
        logic [15:0] xa, xb;
        logic        xc, xs;
        int          sent, got, stalls;
        sent = 0; got = 0; stalls = 0; first = -1; last = -1;
        xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom); xs = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            out_ready = !(c >= st_start && c < st_start + st_len);
            if (sent < nbeats) begin
                a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                check({tag, "_stall_in_ready"}, in_ready, 0);
                if (q.size() > 0) begin
                    check({tag, "_stall_sum"},  sum,  q[0][15:0]);
                    check({tag, "_stall_cout"}, cout, q[0][16]);
                    check({tag, "_stall_ovf"},  ovf,  q[0][17]);
                end else begin
                    check({tag, "_stall_spurious"}, out_valid, 0);
                end
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check({tag, "_extra_result"}, out_valid, 0);
                end else begin
                    cur = q.pop_front();
                    check({tag, "_sum"},  sum,  cur[15:0]);
                    check({tag, "_cout"}, cout, cur[16]);
                    check({tag, "_ovf"},  ovf,  cur[17]);
                    got++;
                    if (first < 0) first = c;
                    last = c;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(xa, xb, xc, xs));
                sent++;
                xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom); xs = sent[0];
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check({tag, "_results"},   got,      nbeats);
        check({tag, "_leftover"},  q.size(), 0);
        check({tag, "_stall_cyc"}, stalls,   st_len);
    endtask

    int first, last;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_sum",       sum,       0);
        check("rst_cout",      cout,      0);
        check("rst_ovf",       ovf,       0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        one_beat("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        one_beat("add_ovf",    16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        one_beat("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        one_beat("sub_bin",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFE, 1'b1, 1'b1);

        run_stream("stream", 8, 1000, 0, 14, first, last);
        check("stream_first", first,        S);
        check("stream_span",  last - first, 7);

        run_stream("bp", 6, 4, 3, 16, first, last);
        check("bp_first", first, 7);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0100 + 16'(i); b = 16'h0010; cin = 1'b0; sub = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sum",       sum,       0);
        #1;
        check("midrst_in_ready",  in_ready,  1);
        for (int i = 0; i < 6; i++) begin
            check("midrst_stale", out_valid, 0);
            tick();
        end
        one_beat("after_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
Parametrised, pipelined two's-complement adder/subtractor. Operands are split into STAGES chunks of CHUNK bits. One chunk is resolved per pipeline stage, and the carry is registered between stages, so WIDTH scales without a long ripple path. It sits in the datapath wherever wide add/sub is needed at full clock rate. Valid/ready handshakes are provided on both sides.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of STAGES.
STAGES, 4, number of pipeline stages; CHUNK = WIDTH/STAGES bits are resolved per stage. STAGES=1 gives a registered full-width ripple adder.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for add; borrow-in for sub
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry out of the MSB (in sub mode: 1 = no borrow)
ovf  output  1  signed overflow

Behaviour:
- Reset is synchronous and active-high on clk; rst takes priority over everything. On reset: all stage valid bits = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, all carry registers = 0. in_ready = 1 in the cycle after rst deasserts.
- Reset mid-operation discards every in-flight beat; no result is emitted for it.
- Arithmetic: effective B is b when sub=0, ~b when sub=1. Effective carry-in is cin when sub=0, !cin when sub=1.
  - Add: sum = (a + b + cin) mod 2^WIDTH.
  - Sub: sum = (a - b - cin) mod 2^WIDTH.
- cout = raw carry out of bit WIDTH-1 of the internal adder.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Pipeline, on acceptance:
  - Stage 0 adds chunk 0 of a and effective B with the effective carry-in, and registers the result chunk and the carry.
  - Stage k (k ≥ 1) adds chunk k using the carry registered by stage k-1.
  - Upper operand chunks travel through skew registers; resolved lower chunks travel through deskew registers. The full result, cout and ovf therefore appear together at the output stage.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+STAGES-1. That is STAGES cycles from in_valid/in_ready to out_valid.
- Throughput: one beat per cycle while out_ready=1.
- Handshake: a beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=0, every pipeline register, including the output, holds its value.
  - sum, cout and ovf stay stable while out_valid=1 and out_ready=0.
- Bubbles: a stage with valid=0 advances with the pipeline. Bubbles are not collapsed, and in_ready does not depend on internal bubbles.
- Simultaneous consume and accept: permitted in the same cycle with no loss.
- Combinational paths: in_ready depends combinationally on out_ready and the output valid only. There is no combinational path from a, b, cin or sub to any output.
- Operands and sub are captured per beat; mixed add/sub beats may be interleaved freely.

Decomposition:
- Shared package/include: the default WIDTH and STAGES constants, and the derived CHUNK localparam.
- Elaboration check: WIDTH % STAGES == 0 and STAGES ≥ 1; otherwise a $error/$fatal-style message.
- One sub-module, rca_chunk: a combinational CHUNK-bit ripple-carry adder built from full-adder cells. It outputs the sum chunk, the carry-out, and the carry into its MSB, which is used for ovf in the top chunk. It is instantiated STAGES times via generate.

Test Plan:
(All at WIDTH=16, STAGES=4.)
- Add with full carry ripple: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 → exactly 4 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0.
- Signed overflow / carry-in: a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, cout=0, ovf=1.
- Subtract with borrow, then borrow-in: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001, sub=1, cin=1 → sum=0x7FFE, cout=1, ovf=1.
- Streaming: 8 back-to-back random beats with alternating sub and out_ready=1 → 8 consecutive out_valid cycles, each result matching the reference model, in order.
- Backpressure: out_ready held 0 for 3 cycles while a result is valid → in_ready=0, and sum/cout/ovf unchanged during the stall. After release, no beat is lost or duplicated.
- Reset mid-stream: assert rst with 3 beats in flight → the next cycle out_valid=0 and sum=0. No stale result is emitted after rst deasserts, and the first new beat returns after 4 cycles.
